// File: rtl/inv_sub_word.sv
// inv_sub_word: serial AES InvSubBytes over one NUM_BYTES-byte word.
// One byte per cycle: inverse affine, map into GF((2^4)^2), invert there
// with GF(2^4) squarer/multiplier/sum/multiply-by-e/inverse blocks, map back.
// The field isomorphism is derived at elaboration from a root of the AES
// polynomial in the composite field, so the map matrices always match the
// chosen GF(2^4) / GF((2^4)^2) polynomials.
module inv_sub_word #(
  parameter int NUM_BYTES = 4,
  parameter int PIPE      = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [8*NUM_BYTES-1:0] data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [8*NUM_BYTES-1:0] data_o,
  output logic                   busy_o
);

  localparam int W  = 8 * NUM_BYTES;
  localparam int CW = $clog2(NUM_BYTES);
  localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);

  // ---------------- GF(2^4) primitives, modulus x^4+x+1 ----------------
  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++)
      if (b[i]) p ^= ({3'b000, a} << i);
    for (int k = 6; k >= 4; k--)
      if (p[k]) p ^= (7'b0010011 << (k - 4));
    return p[3:0];
  endfunction

  function automatic logic [3:0] gf4_sq(input logic [3:0] a);
    return {a[3], a[3] ^ a[1], a[2], a[2] ^ a[0]};
  endfunction

  // Multiply by the composite-field constant lambda = 0xE.
  function automatic logic [3:0] gf4_mul_e(input logic [3:0] a);
    return gf4_mul(a, 4'hE);
  endfunction

  // a^14 = a^-1 (0 maps to 0), built from squarers and multipliers.
  function automatic logic [3:0] gf4_inv(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = gf4_sq(a);
    a4 = gf4_sq(a2);
    a8 = gf4_sq(a4);
    return gf4_mul(gf4_mul(a8, a4), a2);
  endfunction

  // ---------------- GF((2^4)^2), modulus y^2+y+lambda ----------------
  function automatic logic [7:0] comp_mul(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] hh;
    hh = gf4_mul(a[7:4], b[7:4]);
    return {hh ^ gf4_mul(a[7:4], b[3:0]) ^ gf4_mul(a[3:0], b[7:4]),
            gf4_mul_e(hh) ^ gf4_mul(a[3:0], b[3:0])};
  endfunction

  // (g1 y + g0)^-1 = (g1 d) y + (g1 + g0) d, d = (g1^2 lambda + g1 g0 + g0^2)^-1
  function automatic logic [7:0] comp_inv(input logic [7:0] g);
    logic [3:0] d, di;
    d  = gf4_mul_e(gf4_sq(g[7:4])) ^ gf4_mul(g[7:4], g[3:0]) ^ gf4_sq(g[3:0]);
    di = gf4_inv(d);
    return {gf4_mul(g[7:4], di), gf4_mul(g[7:4] ^ g[3:0], di)};
  endfunction

  // Linear map given by eight 8-bit columns.
  function automatic logic [7:0] map_apply(input logic [63:0] cols, input logic [7:0] a);
    logic [7:0] y;
    y = '0;
    for (int i = 0; i < 8; i++)
      if (a[i]) y ^= cols[8*i +: 8];
    return y;
  endfunction

  // Columns r^0..r^7 for the first root r of x^8+x^4+x^3+x+1 in the composite field.
  function automatic logic [63:0] gen_map_cols();
    logic [63:0] cols, cand;
    logic [7:0]  pw, acc, rb;
    logic        found;
    cols  = '0;
    cand  = '0;
    found = 1'b0;
    for (int r = 2; r < 256; r++) begin
      rb  = r[7:0];
      pw  = 8'h01;
      acc = 8'h00;
      for (int k = 0; k < 9; k++) begin
        if (k < 8) cand[8*k +: 8] = pw;
        if (k == 0 || k == 1 || k == 3 || k == 4 || k == 8) acc ^= pw;
        pw = comp_mul(pw, rb);
      end
      if (!found && acc == 8'h00) begin
        found = 1'b1;
        cols  = cand;
      end
    end
    return cols;
  endfunction

  // Inverse map columns: the preimage of each unit vector.
  function automatic logic [63:0] gen_imap_cols(input logic [63:0] cols);
    logic [63:0] icols;
    logic [7:0]  av;
    icols = '0;
    for (int j = 0; j < 8; j++)
      for (int a = 1; a < 256; a++) begin
        av = a[7:0];
        if (map_apply(cols, av) == (8'h01 << j)) icols[8*j +: 8] = av;
      end
    return icols;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] a);
    return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
  endfunction

  localparam logic [63:0] MAP_COLS  = gen_map_cols();
  localparam logic [63:0] IMAP_COLS = gen_imap_cols(MAP_COLS);

  // ---------------- control ----------------
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          issued_q, issued_d;
  logic [W-1:0]  shift_q;

  logic          accept, issue, wr_en, last_write;
  logic [CW-1:0] wr_lane;
  logic [7:0]    stage1_byte, stage2_byte, result_byte;

  assign accept      = (state_q == IDLE) && in_valid_i;
  assign issue       = (state_q == BUSY) && !issued_q;
  assign last_write  = wr_en && (wr_lane == LAST);
  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);

  // Byte datapath: front half (affine + map) and back half (inversion + inverse map).
  always_comb begin
    stage1_byte = map_apply(MAP_COLS, inv_affine(shift_q[7:0]));
    result_byte = map_apply(IMAP_COLS, comp_inv(stage2_byte));
  end

  generate
    if (PIPE != 0) begin : g_pipe
      logic [7:0]    s2_byte_q;
      logic [CW-1:0] s2_lane_q;
      logic          s2_vld_q;
      // Pipeline register between the map stage and the inversion stage.
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          s2_byte_q <= '0;
          s2_lane_q <= '0;
          s2_vld_q  <= 1'b0;
        end else begin
          s2_vld_q <= issue;
          if (issue) begin
            s2_byte_q <= stage1_byte;
            s2_lane_q <= cnt_q;
          end
        end
      end
      assign stage2_byte = s2_byte_q;
      assign wr_lane     = s2_lane_q;
      assign wr_en       = s2_vld_q;
    end else begin : g_nopipe
      assign stage2_byte = stage1_byte;
      assign wr_lane     = cnt_q;
      assign wr_en       = issue;
    end
  endgenerate

  // FSM, byte counter and issue-complete flag: state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      issued_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      issued_q <= issued_d;
    end
  end

  // Next state: the counter saturates at the last byte instead of wrapping.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    issued_d = issued_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d  = BUSY;
          cnt_d    = '0;
          issued_d = 1'b0;
        end
      end
      BUSY: begin
        if (issue) begin
          if (cnt_q == LAST) issued_d = 1'b1;
          else               cnt_d    = cnt_q + 1'b1;
        end
        if (last_write) state_d = DONE;
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Input shift register: captured on accept, consumed LSB byte first.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)     shift_q <= '0;
    else if (accept) shift_q <= data_i;
    else if (issue)  shift_q <= {8'h00, shift_q[W-1:8]};
  end

  generate
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
      logic [7:0] lane_q;
      // Output lane gi: written only by its own result byte.
      always_ff @(posedge clk_i) begin
        if (!rst_ni)                             lane_q <= '0;
        else if (wr_en && wr_lane == CW'(gi))    lane_q <= result_byte;
      end
      assign data_o[8*gi +: 8] = lane_q;
    end
  endgenerate

endmodule
